shift_rows_stream: RTL and testbench
====================================

Name: shift_rows_stream

Overview:
- Parametrised, pipelined ShiftRows / InvShiftRows unit for the AES/Rijndael datapath.
- Supports Rijndael block widths NB = 4, 6 or 8 columns and a per-transfer forward/inverse mode.
- Each transformed block is registered into a DEPTH-entry output buffer, with valid/ready handshakes on both sides.
- Sits between SubBytes and MixColumns in a round core, and is shared by the encrypt and decrypt paths.

Parameters:
- NB, 4, number of state columns; legal values 4, 6, 8; any other value must fail elaboration.
- DEPTH, 2, output buffer entries; power of two, at least 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of the buffer contents
- in_valid  input  1  input block valid
- in_ready  output  1  unit can accept a block this cycle
- in_inv  input  1  0 = ShiftRows, 1 = InvShiftRows; sampled with in_data
- in_data  input  32*NB  input state, indexed [0:32*NB-1]
- out_valid  output  1  out_data holds a valid block
- out_ready  input  1  downstream accepts the block
- out_data  output  32*NB  transformed state, indexed [0:32*NB-1]
- out_inv  output  1  mode used for the block on out_data
- level  output  clog2(DEPTH+1)  number of occupied buffer entries

Behaviour:
- Clock and reset: one clock, clk; reset is rst_n, asynchronous and active-low.
- State layout is row-major, with bit 0 as the MSB of byte 0.
  - Byte k occupies bits [8k:8k+7].
  - Row r (0..3) holds bytes r*NB .. r*NB+NB-1; column c of row r is byte r*NB+c.
- Row shift offsets s_r:
  - NB = 4 or 6: 0, 1, 2, 3.
  - NB = 8: 0, 1, 3, 4.
- Forward mode: out[r][c] = in[r][(c+s_r) mod NB], i.e. each row rotates left by s_r bytes.
- Inverse mode: out[r][c] = in[r][(c-s_r+NB) mod NB].
- The permutation is pure wiring. The only registers are the buffer storage, the write/read pointers and the occupancy counter.
- Accept: a transfer occurs when in_valid and in_ready are both 1.
  - The transformed data and in_inv are written at the write pointer.
  - The write pointer advances, wrapping modulo DEPTH.
- Issue: a transfer occurs when out_valid and out_ready are both 1.
  - The read pointer advances, wrapping modulo DEPTH.
- Latency: a block accepted at edge N appears on out_valid/out_data after edge N, i.e. one cycle into an empty buffer.
- Order: strict FIFO.
- Handshake outputs:
  - in_ready = (level < DEPTH). It is registered-state only and has no combinational path from out_ready.
  - out_valid = (level != 0).
  - out_data and out_inv come from the entry at the read pointer.
- Stability: while out_valid = 1 and out_ready = 0, out_data and out_inv must hold stable.
- Simultaneous accept and issue: level is unchanged and both pointers advance. This is legal when full only if in_ready was 1, so no accept is possible when full even if out_ready = 1.
- Full: in_ready = 0. in_valid is ignored and no write occurs.
- Empty: out_valid = 0. out_ready is ignored.
- Mode per entry: in_inv is stored with each entry, so forward and inverse blocks may interleave back-to-back.
- Flush:
  - At the next edge, level = 0 and both pointers = 0.
  - Any accept or issue in that cycle is discarded.
  - Flush takes priority over all handshakes.
- Reset values (asynchronous, any time, including mid-stream): level = 0, pointers = 0, out_valid = 0, in_ready = 1 after reset release, out_inv = 0, out_data = 0.
  - All storage entries are cleared to 0, so out_data reads 0 when empty.
- Out-of-range parameters: NB not in {4,6,8} or DEPTH not a power of two ≥ 2 produce an elaboration error via a generate-time check.

Test Plan:
- Forward, NB=4: in bytes 00..0F, in_inv=0.
  - out rows: 00 01 02 03 | 05 06 07 04 | 0A 0B 08 09 | 0F 0C 0D 0E.
  - out_valid rises one cycle after accept; out_inv=0.
- Inverse, NB=4: feed the forward result above with in_inv=1 → out bytes 00..0F; out_inv=1.
  - Also check a random 128-bit vector round-trips through forward then inverse.
- Forward, NB=8: in bytes 00..1F.
  - row1 = 09 0A 0B 0C 0D 0E 0F 08.
  - row2 = 13 14 15 16 17 10 11 12.
  - row3 = 1C 1D 1E 1F 18 19 1A 1B.
  - row0 unchanged.
- Forward, NB=6: row3 bytes 12..17 → 15 16 17 12 13 14.
- Backpressure, DEPTH=2: out_ready=0, push blocks A, B.
  - level=2, in_ready=0; a third block C presented is ignored and out_data stays A.
  - Raise out_ready: A then B are issued in order, and in_ready returns to 1 the cycle after A's issue.
- Simultaneous accept/issue at level=1 with alternating in_inv:
  - level stays 1.
  - Outputs come out in order, each with the correct mode.
  - Sustained throughput is 1 block/cycle.
- Flush and reset:
  - At level=2, assert flush with in_valid=1 → next cycle level=0, out_valid=0, and the pending input is not stored.
  - Assert rst_n=0 asynchronously mid-stream → outputs reset immediately, without waiting for a clock edge, and in_ready=1 after release.

Source files
------------

// File: rtl/shift_rows_stream.sv
// AES/Rijndael ShiftRows / InvShiftRows stage with a small output FIFO.
// The row permutation is pure wiring. Each accepted block is stored with
// its mode bit, so forward and inverse blocks can be interleaved freely.
// State layout is row-major: byte k occupies bits [8k:8k+7], and bit 0 is
// the MSB of byte 0. Row r holds bytes r*NB .. r*NB+NB-1.
module shift_rows_stream #(
    parameter int NB    = 4,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_inv,
    input  logic [0:32*NB-1]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [0:32*NB-1]             out_data,
    output logic                         out_inv,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int W  = 32 * NB;
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Reject unsupported geometries at elaboration time.
    generate
        if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
            $error("shift_rows_stream: NB must be 4, 6 or 8");
        end
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("shift_rows_stream: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [0:W-1] fwd_data;
    logic [0:W-1] inv_data;
    logic [0:W-1] shifted;

    // Row rotations. Offsets are 0,1,2,3, except NB=8, which uses 0,1,3,4.
    generate
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int S = (NB == 8 && r >= 2) ? r + 1 : r;
            for (genvar c = 0; c < NB; c++) begin : g_col
                localparam int FS = (c + S) % NB;
                localparam int IS = (c - S + NB) % NB;
                assign fwd_data[8*(r*NB+c) +: 8] = in_data[8*(r*NB+FS) +: 8];
                assign inv_data[8*(r*NB+c) +: 8] = in_data[8*(r*NB+IS) +: 8];
            end
        end
    endgenerate

    assign shifted = in_inv ? inv_data : fwd_data;

    logic [0:W-1]  mem_data [DEPTH];
    logic          mem_inv  [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_nxt;
    logic [PW-1:0] rd_ptr_nxt;
    logic [LW-1:0] level_nxt;
    logic          do_push;
    logic          do_pop;

    // in_ready depends only on the stored occupancy, never on out_ready, so
    // a full buffer cannot accept a block even while it is draining.
    assign in_ready  = (level < LW'(DEPTH));
    assign out_valid = (level != '0);
    assign do_push   = in_valid & in_ready;
    assign do_pop    = out_valid & out_ready;

    assign out_data  = mem_data[rd_ptr];
    assign out_inv   = mem_inv[rd_ptr];

    // Pointer and occupancy update. Flush overrides both handshakes.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        level_nxt  = level;
        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            level_nxt  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_nxt = wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_nxt = rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_nxt = level + LW'(1);
                2'b01:   level_nxt = level - LW'(1);
                default: level_nxt = level;
            endcase
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            level  <= level_nxt;
        end
    end

    // Storage. It is cleared on reset and on flush, so an empty buffer
    // presents zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_inv[i]  <= 1'b0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_inv[i]  <= 1'b0;
            end
        end else if (do_push) begin
            mem_data[wr_ptr] <= shifted;
            mem_inv[wr_ptr]  <= in_inv;
        end
    end

endmodule

// File: tb/tb_shift_rows_stream.sv
// Directed bench for shift_rows_stream. The main NB=4 instance is checked
// through a scoreboard. The NB=8 and NB=6 instances are checked against
// fixed expected vectors.
module tb_shift_rows_stream;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic         in_inv;
    logic [0:127] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] out_data;
    logic         out_inv;
    logic [1:0]   level;

    logic         in_valid8, in_ready8, out_valid8, out_inv8;
    logic [0:255] in_data8, out_data8;
    logic [1:0]   level8;
    logic         in_valid6, in_ready6, out_valid6, out_inv6;
    logic [0:191] in_data6, out_data6;
    logic [1:0]   level6;

    shift_rows_stream #(.NB(4), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_inv(out_inv), .level(level)
    );

    shift_rows_stream #(.NB(8), .DEPTH(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_inv(1'b0), .in_data(in_data8),
        .out_valid(out_valid8), .out_ready(1'b0), .out_data(out_data8),
        .out_inv(out_inv8), .level(level8)
    );

    shift_rows_stream #(.NB(6), .DEPTH(2)) dut6 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(in_valid6), .in_ready(in_ready6), .in_inv(1'b0), .in_data(in_data6),
        .out_valid(out_valid6), .out_ready(1'b0), .out_data(out_data6),
        .out_inv(out_inv6), .level(level6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [0:127] data;
        logic         inv;
    } exp_t;

    exp_t sb[$];
    int   compared;
    int   mismatched;

    localparam logic [0:127] SEQ4 = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [0:127] FWD4 = 128'h00010203050607040A0B08090F0C0D0E;
    localparam logic [0:255] FWD8 =
        256'h0001020304050607090A0B0C0D0E0F0813141516171011121C1D1E1F18191A1B;
    localparam logic [0:191] FWD6 =
        192'h0001020304050708090A0B060E0F10110C0D151617121314;

    // Reference NB=4 permutation: row r rotates by r bytes.
    function automatic logic [0:127] model4(input logic [0:127] d, input logic inv);
        logic [0:127] o;
        int src;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                src = inv ? ((c + 4 - r) % 4) : ((c + r) % 4);
                o[8*(4*r+c) +: 8] = d[8*(4*r+src) +: 8];
            end
        end
        return o;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sample handshakes mid-cycle, update the scoreboard, then advance one
    // edge and return 1 time unit after it.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_issue", 256'(1), 256'(0));
                end else begin
                    e = sb.pop_front();
                    check("sb_data", 256'(out_data), 256'(e.data));
                    check("sb_inv", 256'(out_inv), 256'(e.inv));
                end
            end
            if (in_valid && in_ready) begin
                e.data = model4(in_data, in_inv);
                e.inv  = in_inv;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [0:127] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [0:127] r_vec, tmp, blk_a;

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_inv     = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        in_valid8  = 1'b0;
        in_valid6  = 1'b0;
        for (int k = 0; k < 32; k++) in_data8[8*k +: 8] = 8'(k);
        for (int k = 0; k < 24; k++) in_data6[8*k +: 8] = 8'(k);

        // Reset state
        #12;
        check("rst_level", 256'(level), 256'(0));
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_out_data", 256'(out_data), 256'(0));
        check("rst_out_inv", 256'(out_inv), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 256'(in_ready), 256'(1));

        // Forward NB=4 with one-cycle latency; NB=8 and NB=6 run alongside
        in_data   = SEQ4;
        in_inv    = 1'b0;
        in_valid  = 1'b1;
        in_valid8 = 1'b1;
        in_valid6 = 1'b1;
        check("fwd4_pre_valid", 256'(out_valid), 256'(0));
        cycle();
        in_valid  = 1'b0;
        in_valid8 = 1'b0;
        in_valid6 = 1'b0;
        check("fwd4_valid", 256'(out_valid), 256'(1));
        check("fwd4_data", 256'(out_data), 256'(FWD4));
        check("fwd4_inv", 256'(out_inv), 256'(0));
        check("fwd4_level", 256'(level), 256'(1));
        check("fwd8_data", 256'(out_data8), 256'(FWD8));
        check("fwd6_data", 256'(out_data6), 256'(FWD6));

        // Inverse NB=4: accept while issuing at level 1
        in_data   = FWD4;
        in_inv    = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        check("inv4_level", 256'(level), 256'(1));
        check("inv4_data", 256'(out_data), 256'(SEQ4));
        check("inv4_inv", 256'(out_inv), 256'(1));
        cycle();
        check("inv4_drained", 256'(out_valid), 256'(0));

        // Random round trip
        r_vec    = rnd128();
        in_data  = r_vec;
        in_inv   = 1'b0;
        in_valid = 1'b1;
        cycle();
        tmp      = out_data;
        in_data  = tmp;
        in_inv   = 1'b1;
        cycle();
        in_valid = 1'b0;
        check("roundtrip_data", 256'(out_data), 256'(r_vec));
        check("roundtrip_inv", 256'(out_inv), 256'(1));
        cycle();
        check("roundtrip_empty", 256'(level), 256'(0));

        // Backpressure
        out_ready = 1'b0;
        blk_a     = rnd128();
        in_data   = blk_a;
        in_inv    = 1'b0;
        in_valid  = 1'b1;
        cycle();
        in_data   = rnd128();
        in_inv    = 1'b1;
        cycle();
        check("bp_level_full", 256'(level), 256'(2));
        check("bp_in_ready", 256'(in_ready), 256'(0));
        in_data   = rnd128();
        in_inv    = 1'b0;
        cycle();
        in_valid  = 1'b0;
        check("bp_c_ignored", 256'(level), 256'(2));
        check("bp_head_a", 256'(out_data), 256'(model4(blk_a, 1'b0)));
        out_ready = 1'b1;
        cycle();
        check("bp_ready_back", 256'(in_ready), 256'(1));
        check("bp_level_1", 256'(level), 256'(1));
        cycle();
        check("bp_level_0", 256'(level), 256'(0));

        // Back-to-back with alternating modes at level 1
        in_data  = rnd128();
        in_inv   = 1'b0;
        in_valid = 1'b1;
        cycle();
        for (int i = 0; i < 8; i++) begin
            in_data = rnd128();
            in_inv  = 1'(i % 2 == 0);
            cycle();
            check("stream_level", 256'(level), 256'(1));
        end
        in_valid = 1'b0;
        cycle();
        check("stream_drained", 256'(level), 256'(0));
        check("stream_sb_empty", 256'(sb.size()), 256'(0));

        // Flush
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = rnd128();
        cycle();
        in_data   = rnd128();
        cycle();
        check("flush_pre_level", 256'(level), 256'(2));
        out_ready = 1'b1;
        flush     = 1'b1;
        in_data   = rnd128();
        cycle();
        flush     = 1'b0;
        in_valid  = 1'b0;
        check("flush_level", 256'(level), 256'(0));
        check("flush_out_valid", 256'(out_valid), 256'(0));
        check("flush_in_ready", 256'(in_ready), 256'(1));
        cycle();
        check("flush_not_stored", 256'(level), 256'(0));

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inv    = 1'b1;
        in_data   = rnd128();
        cycle();
        in_valid  = 1'b0;
        check("arst_pre_level", 256'(level), 256'(1));
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("arst_level", 256'(level), 256'(0));
        check("arst_out_valid", 256'(out_valid), 256'(0));
        check("arst_out_data", 256'(out_data), 256'(0));
        check("arst_out_inv", 256'(out_inv), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("arst_in_ready", 256'(in_ready), 256'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
